// File: rtl/add8_rr_sched_pkg.sv
// Shared definitions for the round-robin add scheduler: FSM states and
// the width of the completed-transaction counter.
package add8_rr_sched_pkg;

    localparam int TXN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/add8_rr_sched_add8.sv
// Library 8-bit combinational adder: two 8-bit operands, 9-bit result
// including the carry out.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add8_rr_sched_rr_arb.sv
// Round-robin arbiter: the search starts one past the pointer (the last
// granted index) and the first requesting index found gets a one-hot grant.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    // Walk the requesters starting at ptr+1, wrapping at NREQ.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/add8_rr_sched.sv
// Round-robin scheduler sharing one 8-bit adder among NREQ requesters.
// Each grant runs IDLE -> CALC -> OUT, so at most one result per 3 cycles.
module add8_rr_sched
    import add8_rr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0][7:0] req_a,
    input  logic [NREQ-1:0][7:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8:0]           res_sum,
    output logic [IDW-1:0]       res_id,
    output logic [TXN_W-1:0]     txn_cnt
);

    state_t             state_q;
    logic [IDW-1:0]     last_grant_q;
    logic [7:0]         op_a_q;
    logic [7:0]         op_b_q;
    logic [IDW-1:0]     op_id_q;
    logic [8:0]         res_sum_q;
    logic [IDW-1:0]     res_id_q;
    logic               res_valid_q;
    logic [TXN_W-1:0]   txn_cnt_q;
    logic [TXN_W-1:0]   txn_cnt_d;

    logic [NREQ-1:0]    arb_grant;
    logic [IDW-1:0]     arb_grant_id;
    logic [8:0]         add_sum;
    logic               transfer;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req      (req_valid),
        .ptr      (last_grant_q),
        .grant    (arb_grant),
        .grant_id (arb_grant_id)
    );

    add8 u_add8 (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (add_sum)
    );

    // Grants are only offered while idle and out of reset.
    assign req_ready = (state_q == IDLE && !rst) ? arb_grant : '0;
    assign transfer  = |(req_valid & req_ready);
    assign txn_cnt_d = txn_cnt_q + TXN_W'(1);

    // Scheduler FSM with registered result, pointer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            res_sum_q    <= '0;
            res_id_q     <= '0;
            res_valid_q  <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        op_a_q       <= req_a[arb_grant_id];
                        op_b_q       <= req_b[arb_grant_id];
                        op_id_q      <= arb_grant_id;
                        last_grant_q <= arb_grant_id;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    res_sum_q   <= add_sum;
                    res_id_q    <= op_id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        txn_cnt_q   <= txn_cnt_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: doc/add8_rr_sched.md
ADD8_RR_SCHED -- requirements
Module: add8_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IDW, default 2, width of requester ID; equals clog2(NREQ).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_a  input  NREQ x 8  per-requester operand A.
REQ-007 SHALL have port req_b  input  NREQ x 8  per-requester operand B.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; a transfer occurs on bit i when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res_sum  output  9  registered 9-bit sum from the shared 8-bit adder.
REQ-012 SHALL have port res_id  output  IDW  requester index that owns res_sum.
REQ-013 SHALL have port txn_cnt  output  16  count of completed result handshakes.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, OUT.
REQ-015 In IDLE with any req_valid high, SHALL assert exactly one req_ready bit, chosen round-robin, and move to CALC on the next edge.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod NREQ; last_grant SHALL update only on a transfer.
REQ-017 req_ready SHALL be combinational from req_valid and the pointer, and SHALL be all-zero outside IDLE.
REQ-018 On transfer, SHALL latch req_a, req_b and the granted index into operand registers.
REQ-019 In CALC, SHALL drive the latched operands into the shared adder, register its 9-bit output into res_sum and the index into res_id, then go to OUT.
REQ-020 The adder result SHALL be passed unmodified; no exact correction is applied, and adder error is not the scheduler's concern.
REQ-021 In OUT, SHALL hold res_valid=1 and keep res_sum/res_id stable until res_ready=1.
REQ-022 On the OUT edge with res_ready=1, SHALL go to IDLE, deassert res_valid and increment txn_cnt modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-023 Minimum latency from transfer to res_valid SHALL be 2 cycles; maximum throughput SHALL be 1 result per 3 cycles.
REQ-024 A requester that drops req_valid while not granted SHALL lose nothing; the pointer SHALL remain unchanged.
REQ-025 With NREQ requesters continuously valid, each SHALL be granted once within every NREQ consecutive grants.
REQ-026 res_ready high while res_valid is low SHALL have no effect.

Reset
REQ-027 Asserting rst SHALL immediately force the FSM to IDLE, regardless of current state.
REQ-028 Asserting rst SHALL set res_valid=0, res_sum=0, res_id=0, txn_cnt=0 and last_grant=NREQ-1, so that requester 0 has first priority.
REQ-029 Reset in CALC or OUT SHALL discard the in-flight operation with no result output.
REQ-030 req_ready SHALL be all-zero while rst is high.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, CALC, OUT) and the constant TXN_W=16.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arb, with inputs req/pointer and output one-hot grant.
REQ-033 The adder SHALL be a single instance of the library's 8-bit combinational adder, with 8+8 inputs and a 9-bit output.

Verification
REQ-034 Reset, then req_valid=0001, a=0x10, b=0x20 -> req_ready=0001; 2 cycles later res_valid=1, res_id=0, res_sum equals the adder model for (0x10,0x20); txn_cnt=1 after handshake.
REQ-035 All four valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; results spaced every 3 cycles.
REQ-036 res_ready held low for 10 cycles in OUT -> res_sum/res_id stable, req_ready=0000 throughout.
REQ-037 rst pulsed during CALC -> no res_valid follows, txn_cnt=0, next grant goes to requester 0.
REQ-038 Preload txn_cnt to 0xFFFF via 65535 transactions, then complete one more -> txn_cnt=0x0000.
REQ-039 a=0xFF, b=0xFF on requester 3 -> res_sum equals the adder model's 9-bit output and res_id=3.
